// File: rtl/uart_pinbus_host.sv
// uart_pinbus_host: host-side initiator for the UART test-chip pin interface.
// Turns a TX valid/ready byte stream into chip WRITE cycles, polls the chip
// RX FIFO with READ cycles into a one-entry holding register, and issues
// FIFO CLEAR cycles on request. Every bus operation is followed by a
// turnaround so the host and the chip never drive the data pins together.
// Optional build macro: UART_HOST_STATS_EN adds 16-bit TX/RX byte counters;
// without it the stat ports are tied to zero.
module uart_pinbus_host #(
    parameter int unsigned POLL_CYCLES   = 64,
    parameter int unsigned TURN_CYCLES   = 1,
    parameter logic [7:0]  CLEAR_PATTERN = 8'hFF
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic [1:0]  rate_sel,
    input  logic [7:0]  tx_byte,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic        clear_req,
    output logic        busy,
    output logic        zero_drop,
    output logic [3:0]  pin_control,
    output logic [7:0]  pin_data_out,
    output logic        pin_data_oe,
    input  logic [7:0]  pin_data_in,
    input  logic        pin_rts,
    output logic [15:0] stat_tx_cnt,
    output logic [15:0] stat_rx_cnt
);

    localparam int unsigned    PW        = $clog2(POLL_CYCLES + 1);
    localparam int unsigned    TW        = $clog2(TURN_CYCLES + 1);
    localparam logic [PW-1:0]  POLL_LOAD = PW'(POLL_CYCLES);
    localparam logic [TW-1:0]  TURN_LOAD = TW'(TURN_CYCLES - 1);

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_CLEAR = 3'd2,
        ST_READ  = 3'd3,
        ST_RWAIT = 3'd4,
        ST_TURN  = 3'd5
    } state_t;

    state_t          r_state;
    logic [1:0]      r_op;
    logic            r_oe;
    logic [7:0]      r_dout;
    logic [PW-1:0]   r_poll;
    logic [TW-1:0]   r_turn;
    logic            r_clr_pend;
    logic            r_rx_valid;
    logic [7:0]      r_rx_byte;
    logic            r_zero_drop;

    logic            w_clr_any;
    logic            w_poll_exp;
    logic            w_go_clear;
    logic            w_go_read;
    logic            w_go_tx;

    // A clear requested this very cycle already counts as pending, so it
    // beats a TX byte presented in the same cycle.
    assign w_clr_any  = r_clr_pend | clear_req;
    // The counter expires on the cycle it would step to zero, which leaves
    // exactly POLL_CYCLES idle cycles between speculative reads.
    assign w_poll_exp = (r_poll <= PW'(1));

    // Fixed-priority arbitration among the operations that can start from IDLE
    always_comb begin
        w_go_clear = 1'b0;
        w_go_read  = 1'b0;
        w_go_tx    = 1'b0;
        if (r_state != ST_IDLE) begin
            w_go_clear = 1'b0;
        end else if (w_clr_any) begin
            w_go_clear = 1'b1;
        end else if (pin_rts && !r_rx_valid) begin
            w_go_read = 1'b1;
        end else if (tx_valid) begin
            w_go_tx = 1'b1;
        end else if (w_poll_exp && !r_rx_valid) begin
            w_go_read = 1'b1;
        end else begin
            w_go_read = 1'b0;
        end
    end

    // Bus sequencer: state, registered pin drive, RX holding register, flags
    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_IDLE;
            r_oe        <= 1'b0;
            r_dout      <= 8'h00;
            r_poll      <= POLL_LOAD;
            r_turn      <= TURN_LOAD;
            r_clr_pend  <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_rx_byte   <= 8'h00;
            r_zero_drop <= 1'b0;
        end else begin
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            if (clear_req) begin
                r_clr_pend <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_go_clear) begin
                        r_clr_pend <= 1'b0;
                        r_state    <= ST_CLEAR;
                        r_op       <= OP_CLEAR;
                        r_oe       <= 1'b1;
                        r_dout     <= CLEAR_PATTERN;
                    end else if (w_go_read) begin
                        r_state    <= ST_READ;
                        r_op       <= OP_READ;
                        r_oe       <= 1'b0;
                        r_dout     <= 8'h00;
                    end else if (w_go_tx) begin
                        // The chip ignores 0x00, so such a byte is swallowed here.
                        if (tx_byte != 8'h00) begin
                            r_state <= ST_WRITE;
                            r_op    <= OP_WRITE;
                            r_oe    <= 1'b1;
                            r_dout  <= tx_byte;
                        end else begin
                            r_zero_drop <= 1'b1;
                        end
                    end else if (r_poll != {PW{1'b0}}) begin
                        r_poll <= r_poll - PW'(1);
                    end
                end
                ST_WRITE, ST_CLEAR, ST_RWAIT: begin
                    if (r_state == ST_CLEAR) begin
                        r_rx_valid <= 1'b0;
                    end
                    // Data registered by the chip at the end of READ; 0x00 means empty.
                    if (r_state == ST_RWAIT && pin_data_in != 8'h00) begin
                        r_rx_byte  <= pin_data_in;
                        r_rx_valid <= 1'b1;
                    end
                    r_state <= ST_TURN;
                    r_turn  <= TURN_LOAD;
                    r_op    <= OP_IDLE;
                    r_oe    <= 1'b0;
                    r_dout  <= 8'h00;
                end
                ST_READ: begin
                    r_state <= ST_RWAIT;
                    r_op    <= OP_IDLE;
                    r_oe    <= 1'b0;
                    r_dout  <= 8'h00;
                end
                ST_TURN: begin
                    if (r_turn == {TW{1'b0}}) begin
                        r_state <= ST_IDLE;
                        r_poll  <= POLL_LOAD;
                    end else begin
                        r_turn <= r_turn - TW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_op    <= OP_IDLE;
                    r_oe    <= 1'b0;
                    r_dout  <= 8'h00;
                end
            endcase
        end
    end

`ifdef UART_HOST_STATS_EN
    logic [15:0] r_stat_tx;
    logic [15:0] r_stat_rx;

    // Wrapping counters of bytes written to and nonzero bytes read from the chip
    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_stat_tx <= 16'h0000;
            r_stat_rx <= 16'h0000;
        end else begin
            if (r_state == ST_WRITE) begin
                r_stat_tx <= r_stat_tx + 16'h0001;
            end
            if (r_state == ST_RWAIT && pin_data_in != 8'h00) begin
                r_stat_rx <= r_stat_rx + 16'h0001;
            end
        end
    end

    assign stat_tx_cnt = r_stat_tx;
    assign stat_rx_cnt = r_stat_rx;
`else
    assign stat_tx_cnt = 16'h0000;
    assign stat_rx_cnt = 16'h0000;
`endif

    assign tx_ready     = nReset & w_go_tx;
    assign busy         = (r_state != ST_IDLE);
    assign pin_control  = {r_op, rate_sel};
    assign pin_data_out = r_dout;
    assign pin_data_oe  = r_oe;
    assign rx_byte      = r_rx_byte;
    assign rx_valid     = r_rx_valid;
    assign zero_drop    = r_zero_drop;

endmodule

// File: tb/tb_uart_pinbus_host.sv
// Bench for uart_pinbus_host: a queue-based model predicts the pin cycles
// each launched operation produces and is checked every cycle, alongside
// directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_uart_pinbus_host;

    localparam int         POLL = 4;
    localparam int         TURN = 1;
    localparam logic [7:0] CLRP = 8'hFF;

    logic        clk = 1'b0;
    logic        nReset;
    logic [1:0]  rate_sel;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ready;
    logic        clear_req;
    logic        busy;
    logic        zero_drop;
    logic [3:0]  pin_control;
    logic [7:0]  pin_data_out;
    logic        pin_data_oe;
    logic [7:0]  pin_data_in;
    logic        pin_rts;
    logic [15:0] stat_tx_cnt;
    logic [15:0] stat_rx_cnt;

    always #5 clk = ~clk;

    uart_pinbus_host #(
        .POLL_CYCLES   (POLL),
        .TURN_CYCLES   (TURN),
        .CLEAR_PATTERN (CLRP)
    ) dut (
        .clk          (clk),
        .nReset       (nReset),
        .rate_sel     (rate_sel),
        .tx_byte      (tx_byte),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .clear_req    (clear_req),
        .busy         (busy),
        .zero_drop    (zero_drop),
        .pin_control  (pin_control),
        .pin_data_out (pin_data_out),
        .pin_data_oe  (pin_data_oe),
        .pin_data_in  (pin_data_in),
        .pin_rts      (pin_rts),
        .stat_tx_cnt  (stat_tx_cnt),
        .stat_rx_cnt  (stat_rx_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One pin cycle as seen on the bus; smp marks the cycle whose end samples pin_data_in.
    typedef struct packed {
        logic [1:0] op;
        logic       oe;
        logic [7:0] d;
        logic       smp;
    } pin_t;

    pin_t        q[$];
    pin_t        m_cur;
    bit          m_busy;
    bit          m_rxv;
    logic [7:0]  m_rxb;
    bit          m_zd;
    bit          m_pend;
    int          m_idle;
    logic [15:0] m_txc;
    logic [15:0] m_rxc;
    logic        exp_txr;

    function automatic pin_t mk(input logic [1:0] op, input logic oe, input logic [7:0] d, input logic smp);
        pin_t p;
        p.op = op; p.oe = oe; p.d = d; p.smp = smp;
        return p;
    endfunction

    task m_rst();
        q.delete();
        m_cur  = mk(2'b00, 1'b0, 8'h00, 1'b0);
        m_busy = 1'b0; m_rxv = 1'b0; m_rxb = 8'h00; m_zd = 1'b0;
        m_pend = 1'b0; m_idle = 0; m_txc = 16'h0000; m_rxc = 16'h0000;
    endtask

    // Queue the full pin sequence of an operation: op cycle, [RWAIT], TURN cycles.
    task m_launch(input logic [1:0] op, input logic [7:0] d);
        m_busy = 1'b1;
        m_cur  = mk(op, (op != 2'b10), d, 1'b0);
        if (op == 2'b10) q.push_back(mk(2'b00, 1'b0, 8'h00, 1'b1));
        for (int i = 0; i < TURN; i++) q.push_back(mk(2'b00, 1'b0, 8'h00, 1'b0));
    endtask

    // Advance the model across the coming clock edge using the current inputs.
    task m_step();
        bit   rxv_now;
        pin_t cur;
        if (!nReset) begin
            m_rst();
            return;
        end
        rxv_now = m_rxv;
        cur     = m_cur;
        if (m_rxv && rx_ready) m_rxv = 1'b0;
        if (cur.smp && pin_data_in != 8'h00) begin
            m_rxv = 1'b1; m_rxb = pin_data_in; m_rxc = m_rxc + 16'd1;
        end
        if (cur.op == 2'b01) m_txc = m_txc + 16'd1;
        if (cur.op == 2'b11) m_rxv = 1'b0;
        if (m_busy) begin
            if (clear_req) m_pend = 1'b1;
            if (q.size() > 0) m_cur = q.pop_front();
            else begin
                m_cur = mk(2'b00, 1'b0, 8'h00, 1'b0);
                m_busy = 1'b0;
                m_idle = 0;
            end
        end else if (m_pend || clear_req) begin
            m_pend = 1'b0;
            m_launch(2'b11, CLRP);
        end else if (pin_rts && !rxv_now) begin
            m_launch(2'b10, 8'h00);
        end else if (tx_valid) begin
            if (tx_byte != 8'h00) m_launch(2'b01, tx_byte);
            else m_zd = 1'b1;
        end else if (m_idle >= POLL - 1 && !rxv_now) begin
            m_launch(2'b10, 8'h00);
        end else begin
            m_idle++;
        end
    endtask

    // Every-cycle comparison of all outputs against the model
    initial begin
        m_rst();
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_txr = nReset && !m_busy && !(m_pend || clear_req) && !(pin_rts && !m_rxv) && tx_valid;
            chk("tx_ready",     32'(tx_ready),     32'(exp_txr));
            chk("pin_control",  32'(pin_control),  32'({m_cur.op, rate_sel}));
            chk("pin_data_oe",  32'(pin_data_oe),  32'(m_cur.oe));
            chk("pin_data_out", 32'(pin_data_out), 32'(m_cur.d));
            chk("busy",         32'(busy),         32'(m_busy));
            chk("rx_valid",     32'(rx_valid),     32'(m_rxv));
            chk("rx_byte",      32'(rx_byte),      32'(m_rxb));
            chk("zero_drop",    32'(zero_drop),    32'(m_zd));
`ifdef UART_HOST_STATS_EN
            chk("stat_tx_cnt",  32'(stat_tx_cnt),  32'(m_txc));
            chk("stat_rx_cnt",  32'(stat_rx_cnt),  32'(m_rxc));
`else
            chk("stat_tx_cnt",  32'(stat_tx_cnt),  32'h0);
            chk("stat_rx_cnt",  32'(stat_rx_cnt),  32'h0);
`endif
            m_step();
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a byte and hold it until the handshake; returns at WRITE cycle start.
    task automatic send(input logic [7:0] b, output int nrdy);
        bit hs;
        hs = 1'b0; nrdy = 0;
        tx_byte = b; tx_valid = 1'b1;
        for (int k = 0; k < 60 && !hs; k++) begin
            @(negedge clk);
            if (tx_ready) begin hs = 1'b1; nrdy++; end
            step_cyc();
        end
        tx_valid = 1'b0; tx_byte = 8'h00;
        if (!hs) begin
            n_vec++; n_err++;
            $display("FAIL tx_handshake: no tx_ready within bound for byte %0h", b);
        end
    endtask

    // Wait until the pins show the given op; returns cycles waited or -1.
    task automatic wait_op(input logic [1:0] op, input int bound, output int waited);
        waited = -1;
        for (int k = 0; k < bound && waited < 0; k++) begin
            @(negedge clk);
            if (pin_control[3:2] == op) waited = k;
            step_cyc();
        end
    endtask

    int   nrdy, w1, w2, reads, clr_at, wr_at;
    bit   got, hs;
    logic [7:0] clr_d, wr_d;

    initial begin
        nReset = 1'b0; rate_sel = 2'b01; tx_byte = 8'h00; tx_valid = 1'b0;
        rx_ready = 1'b0; clear_req = 1'b0; pin_data_in = 8'h00; pin_rts = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_op",        32'(pin_control[3:2]), 32'h0);
        chk("rst_oe",        32'(pin_data_oe),      32'h0);
        chk("rst_busy",      32'(busy),             32'h0);
        chk("rst_rx_valid",  32'(rx_valid),         32'h0);
        chk("rst_zero_drop", 32'(zero_drop),        32'h0);
        step_cyc();
        nReset = 1'b1;

        // Plain write of 0x5A
        send(8'h5A, nrdy);
        chk("wr5a_ready_cycles", 32'(nrdy), 32'd1);
        @(negedge clk);
        chk("wr5a_op",   32'(pin_control[3:2]), 32'h1);
        chk("wr5a_oe",   32'(pin_data_oe),      32'h1);
        chk("wr5a_data", 32'(pin_data_out),     32'h5A);
        chk("wr5a_txr",  32'(tx_ready),         32'h0);
        @(negedge clk);
        chk("wr5a_turn_op", 32'(pin_control[3:2]), 32'h0);
        chk("wr5a_turn_oe", 32'(pin_data_oe),      32'h0);
        step_cyc();

        // Zero byte dropped, then 0x11 written
        send(8'h00, nrdy);
        @(negedge clk);
        chk("zero_no_write", 32'(pin_control[3:2]), 32'h0);
        chk("zero_drop_set", 32'(zero_drop),        32'h1);
        step_cyc();
        send(8'h11, nrdy);
        @(negedge clk);
        chk("wr11_op",   32'(pin_control[3:2]), 32'h1);
        chk("wr11_data", 32'(pin_data_out),     32'h11);
        chk("zero_drop_sticky", 32'(zero_drop), 32'h1);
        step_cyc();

        // RTS-driven read returning 0xC3, held while rx_ready=0
        rate_sel = 2'b10;
        pin_data_in = 8'hC3; pin_rts = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (rx_valid) got = 1'b1;
            step_cyc();
        end
        chk("rx_c3_seen", 32'(got),     32'h1);
        chk("rx_c3_byte", 32'(rx_byte), 32'hC3);
        pin_data_in = 8'h00;
        reads = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (pin_control[3:2] == 2'b10) reads++;
            step_cyc();
        end
        chk("rx_hold_no_read", 32'(reads),    32'd0);
        chk("rx_hold_valid",   32'(rx_valid), 32'h1);
        rx_ready = 1'b1;
        step_cyc();
        rx_ready = 1'b0;
        @(negedge clk);
        chk("rx_drop_after_ready", 32'(rx_valid), 32'h0);
        step_cyc();
        wait_op(2'b10, 6, w1);
        chk("rts_read_resumes", 32'(w1 >= 0), 32'h1);
        pin_rts = 1'b0;

        // Idle polling period with empty chip FIFO
        wait_op(2'b10, 20, w1);
        wait_op(2'b10, 20, w2);
        chk("poll_period", 32'(w2 + 1), 32'd7);
        chk("poll_empty_no_valid", 32'(rx_valid), 32'h0);

        // CLEAR wipes the holding register
        pin_data_in = 8'h3C; pin_rts = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (rx_valid) got = 1'b1;
            step_cyc();
        end
        pin_data_in = 8'h00; pin_rts = 1'b0;
        chk("rx_3c_byte", 32'(rx_byte), 32'h3C);
        clear_req = 1'b1;
        step_cyc();
        clear_req = 1'b0;
        wait_op(2'b11, 10, w1);
        @(negedge clk);
        chk("clear_drops_rx_valid", 32'(rx_valid), 32'h0);
        step_cyc();

        // Simultaneous clear_req and tx_valid: CLEAR first, then WRITE 0x22
        rate_sel = 2'b11;
        clear_req = 1'b1; tx_valid = 1'b1; tx_byte = 8'h22;
        clr_at = -1; wr_at = -1; hs = 1'b0; clr_d = 8'h00; wr_d = 8'h00;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (pin_control[3:2] == 2'b11 && clr_at < 0) begin clr_at = k; clr_d = pin_data_out; end
            if (pin_control[3:2] == 2'b01 && wr_at < 0) begin wr_at = k; wr_d = pin_data_out; end
            if (tx_ready) hs = 1'b1;
            step_cyc();
            clear_req = 1'b0;
            if (hs) tx_valid = 1'b0;
        end
        tx_valid = 1'b0;
        chk("clr_seen",        32'(clr_at >= 0),    32'h1);
        chk("clr_data",        32'(clr_d),          32'hFF);
        chk("wr_after_clr",    32'(wr_at > clr_at), 32'h1);
        chk("wr22_data",       32'(wr_d),           32'h22);

        // Reset asserted during a WRITE
        send(8'h77, nrdy);
        nReset = 1'b0; tx_valid = 1'b1; tx_byte = 8'h99;
        @(negedge clk);
        chk("rstw_still_write", 32'(pin_control[3:2]), 32'h1);
`ifdef UART_HOST_STATS_EN
        chk("stat_tx_pre", 32'(stat_tx_cnt), 32'd3);
        chk("stat_rx_pre", 32'(stat_rx_cnt), 32'd2);
`endif
        step_cyc();
        @(negedge clk);
        chk("rstw_op",   32'(pin_control[3:2]), 32'h0);
        chk("rstw_oe",   32'(pin_data_oe),      32'h0);
        chk("rstw_txr",  32'(tx_ready),         32'h0);
        chk("rstw_busy", 32'(busy),             32'h0);
        chk("rstw_zd",   32'(zero_drop),        32'h0);
        chk("rstw_stat_tx", 32'(stat_tx_cnt),   32'h0);
        chk("rstw_stat_rx", 32'(stat_rx_cnt),   32'h0);
        step_cyc();
        nReset = 1'b1; tx_valid = 1'b0; tx_byte = 8'h00;
        repeat (10) step_cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
